// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the pipelined-read register file.
//   DefaultWidth / DefaultNumRegs : default data width and register count
//   ZERO_REG_ARM                  : ARM hardwired-zero register index
//   addr_w(n)                     : address width needed to index n entries
package regfile_pkg;

  localparam int unsigned DefaultWidth   = 64;
  localparam int unsigned DefaultNumRegs = 32;
  localparam int unsigned ZERO_REG_ARM   = 31;

  function automatic int unsigned addr_w(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_rd_pipe_if.sv
// Write/read bus of the register file.
//   master : drives wr_en/wr_addr/wr_data and rd_en/rd_addr, observes rd_data/rd_valid
//   slave  : the register file side
//   rd_addr : port i at [i*AW +: AW]; rd_data : port i at [i*WIDTH +: WIDTH]
interface regfile_rd_pipe_if
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = DefaultWidth,
  parameter int unsigned NUM_REGS = DefaultNumRegs,
  parameter int unsigned NUM_RD   = 2
);

  localparam int unsigned AW = addr_w(NUM_REGS);

  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic [WIDTH-1:0]        wr_data;
  logic [NUM_RD-1:0]       rd_en;
  logic [NUM_RD*AW-1:0]    rd_addr;
  logic [NUM_RD*WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]       rd_valid;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid
  );

endinterface

// File: rtl/muxn_1.sv
// Generic combinational N:1 selector of WIDTH-bit words.
//   data_i : N words, word k at [k*WIDTH +: WIDTH]
//   sel_i  : word index; an index >= N yields zero
//   data_o : selected word
module muxn_1 #(
  parameter int unsigned N     = 32,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned SW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N*WIDTH-1:0] data_i,
  input  logic [SW-1:0]      sel_i,
  output logic [WIDTH-1:0]   data_o
);

  always_comb begin
    data_o = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (32'(sel_i) == k) begin
        data_o = data_i[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/regfile_rd_pipe.sv
// Flop-based register file with NUM_RD registered read ports.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset, clears storage and read outputs
//   bus     : slave side of regfile_rd_pipe_if (one write port, NUM_RD read ports)
// Each read returns one cycle after rd_en. The zero register and out-of-range
// addresses read as 0; with BYPASS=1 a read of the address being written
// returns the incoming write data.
module regfile_rd_pipe
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = DefaultWidth,
  parameter int unsigned NUM_REGS = DefaultNumRegs,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = ZERO_REG_ARM,
  parameter bit          BYPASS   = 1'b1
) (
  input logic              clk,
  input logic              reset_n,
  regfile_rd_pipe_if.slave bus
);

  localparam int unsigned AW = addr_w(NUM_REGS);

  // An address that maps to real, writable storage.
  function automatic logic addr_live(input logic [AW-1:0] a);
    return (32'(a) != ZERO_REG) && (32'(a) < NUM_REGS);
  endfunction

  logic [NUM_REGS-1:0][WIDTH-1:0] regs_q;
  logic                           wr_live;

  assign wr_live = bus.wr_en && addr_live(bus.wr_addr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs_q <= '0;
    end else if (wr_live) begin
      regs_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] stored;
    logic [WIDTH-1:0] sel;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    assign addr = bus.rd_addr[p*AW +: AW];

    muxn_1 #(
      .N     (NUM_REGS),
      .WIDTH (WIDTH)
    ) u_mux (
      .data_i (regs_q),
      .sel_i  (addr),
      .data_o (stored)
    );

    // Zero forcing outranks bypass so the zero register never leaks write data.
    always_comb begin
      if (!addr_live(addr)) begin
        sel = '0;
      end else if (BYPASS && bus.wr_en && (bus.wr_addr == addr)) begin
        sel = bus.wr_data;
      end else begin
        sel = stored;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= bus.rd_en[p];
        if (bus.rd_en[p]) begin
          data_q <= sel;
        end
      end
    end

    assign bus.rd_data[p*WIDTH +: WIDTH] = data_q;
    assign bus.rd_valid[p]               = valid_q;
  end

endmodule
